// File: rtl/usb_rx_line_decoder_if.sv
// rtl/usb_rx_line_decoder_if.sv - USB line pins and decoded bit-stream bundle
interface usb_rx_line_decoder_if;
  logic d_plus;
  logic d_minus;
  logic data_out;
  logic shift_en;
  logic crc_clr;
  logic pkt_active;
  logic eop;
  logic rx_err;

  modport master (
    input  d_plus, d_minus,
    output data_out, shift_en, crc_clr, pkt_active, eop, rx_err
  );

  modport slave (
    output d_plus, d_minus,
    input  data_out, shift_en, crc_clr, pkt_active, eop, rx_err
  );
endinterface

// File: rtl/usb_rx_line_decoder.sv
// rtl/usb_rx_line_decoder.sv - USB RX front end: sync, bit recovery, NRZI, SYNC/stuff/EOP
module usb_rx_line_decoder #(
  parameter int CLKS_PER_BIT = 8,
  parameter int SAMPLE_POINT = 3
) (
  input  logic                         clk,
  input  logic                         n_rst,
  usb_rx_line_decoder_if.master        rx_if
);
  localparam int              CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]   SP_CNT   = CW'(SAMPLE_POINT);
  localparam logic [CW-1:0]   LAST_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [1:0]      LINE_J   = 2'b10;
  localparam logic [1:0]      LINE_K   = 2'b01;
  localparam logic [1:0]      LINE_SE0 = 2'b00;

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_DATA, S_EOP1, S_EOP2, S_ERR, S_ERR_SE0
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [1:0]    r_meta, r_sync, r_prev, r_line;
  logic          r_edge, r_jk;
  logic [CW-1:0] r_cnt;
  logic          r_nrzi_prev;
  logic [2:0]    r_zeros, w_zeros_nxt;
  logic [2:0]    r_ones, w_ones_nxt;
  logic          r_data_out, w_data_nxt;
  logic          r_shift_en, w_shift_nxt;
  logic          r_crc_clr, w_crc_clr_nxt;
  logic          r_pkt_active, w_pkt_nxt;
  logic          r_eop, w_eop_nxt;
  logic          r_rx_err, w_err_nxt;
  logic          w_sample, w_line_jk, w_bit;

  // r_line trails r_prev by one clock so it lines up with the registered edge flag
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_meta <= LINE_J;
      r_sync <= LINE_J;
      r_prev <= LINE_J;
      r_line <= LINE_J;
      r_edge <= 1'b0;
      r_jk   <= 1'b0;
    end else begin
      r_meta <= {rx_if.d_plus, rx_if.d_minus};
      r_sync <= r_meta;
      r_prev <= r_sync;
      r_line <= r_prev;
      r_edge <= (r_sync != r_prev);
      r_jk   <= (r_prev == LINE_J) && (r_sync == LINE_K);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_cnt <= '0;
    end else if (r_state == S_IDLE || r_edge || r_cnt == LAST_CNT) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign w_sample  = (r_state != S_IDLE) && (r_cnt == SP_CNT);
  assign w_line_jk = r_line[1] ^ r_line[0];
  assign w_bit     = (r_line[1] == r_nrzi_prev);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_nrzi_prev <= 1'b1;
    end else if (r_state == S_IDLE) begin
      r_nrzi_prev <= 1'b1;
    end else if (w_sample && w_line_jk) begin
      r_nrzi_prev <= r_line[1];
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state      <= S_IDLE;
      r_zeros      <= '0;
      r_ones       <= '0;
      r_data_out   <= 1'b0;
      r_shift_en   <= 1'b0;
      r_crc_clr    <= 1'b0;
      r_pkt_active <= 1'b0;
      r_eop        <= 1'b0;
      r_rx_err     <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_zeros      <= w_zeros_nxt;
      r_ones       <= w_ones_nxt;
      r_data_out   <= w_data_nxt;
      r_shift_en   <= w_shift_nxt;
      r_crc_clr    <= w_crc_clr_nxt;
      r_pkt_active <= w_pkt_nxt;
      r_eop        <= w_eop_nxt;
      r_rx_err     <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_zeros_nxt   = r_zeros;
    w_ones_nxt    = r_ones;
    w_data_nxt    = r_data_out;
    w_shift_nxt   = 1'b0;
    w_crc_clr_nxt = 1'b0;
    w_pkt_nxt     = r_pkt_active;
    w_eop_nxt     = 1'b0;
    w_err_nxt     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_zeros_nxt = '0;
        w_ones_nxt  = '0;
        if (r_jk) w_state_nxt = S_SYNC;
      end
      S_SYNC: if (w_sample) begin
        if (!w_line_jk) begin
          w_state_nxt = S_ERR;
        end else if (w_bit) begin
          if (r_zeros == 3'd7) begin
            w_state_nxt   = S_DATA;
            w_crc_clr_nxt = 1'b1;
            w_pkt_nxt     = 1'b1;
            w_ones_nxt    = '0;
          end else begin
            w_state_nxt = S_ERR;
          end
        end else if (r_zeros == 3'd7) begin
          w_state_nxt = S_ERR;
        end else begin
          w_zeros_nxt = r_zeros + 3'd1;
        end
      end
      S_DATA: if (w_sample) begin
        if (r_line == LINE_SE0) begin
          w_state_nxt = S_EOP1;
        end else if (!w_line_jk) begin
          w_state_nxt = S_ERR;
        end else if (r_ones == 3'd6) begin
          // six ones in a row: this bit must be a stuffed zero and is dropped
          if (w_bit) w_state_nxt = S_ERR;
          else       w_ones_nxt  = '0;
        end else begin
          w_shift_nxt = 1'b1;
          w_data_nxt  = w_bit;
          w_ones_nxt  = w_bit ? r_ones + 3'd1 : 3'd0;
        end
      end
      S_EOP1: if (w_sample) begin
        w_state_nxt = (r_line == LINE_SE0) ? S_EOP2 : S_ERR;
      end
      S_EOP2: if (w_sample) begin
        if (r_line == LINE_J) begin
          w_state_nxt = S_IDLE;
          w_eop_nxt   = 1'b1;
          w_pkt_nxt   = 1'b0;
        end else if (r_line != LINE_SE0) begin
          w_state_nxt = S_ERR;
        end
      end
      S_ERR: if (w_sample && r_line == LINE_SE0) begin
        w_state_nxt = S_ERR_SE0;
      end
      S_ERR_SE0: if (w_sample) begin
        if (r_line == LINE_J)        w_state_nxt = S_IDLE;
        else if (r_line != LINE_SE0) w_state_nxt = S_ERR;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_state_nxt == S_ERR && r_state != S_ERR && r_state != S_ERR_SE0) begin
      w_err_nxt = 1'b1;
      w_pkt_nxt = 1'b0;
    end
  end

  assign rx_if.data_out   = r_data_out;
  assign rx_if.shift_en   = r_shift_en;
  assign rx_if.crc_clr    = r_crc_clr;
  assign rx_if.pkt_active = r_pkt_active;
  assign rx_if.eop        = r_eop;
  assign rx_if.rx_err     = r_rx_err;
endmodule

// File: tb/tb_usb_rx_line_decoder.sv
// tb/tb_usb_rx_line_decoder.sv - randomized self-checking bench for usb_rx_line_decoder
module tb_usb_rx_line_decoder;
  localparam int         CPB = 8;
  localparam int         SP  = 3;
  localparam logic [1:0] J   = 2'b10;
  localparam logic [1:0] K   = 2'b01;
  localparam logic [1:0] SE0 = 2'b00;

  logic clk   = 1'b0;
  logic n_rst = 1'b0;
  usb_rx_line_decoder_if bus();

  usb_rx_line_decoder #(.CLKS_PER_BIT(CPB), .SAMPLE_POINT(SP)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .rx_if (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // observation side: event logs the scenario tasks compare against
  int cyc = 0;
  bit rx_bits[$];
  int shift_cycs[$];
  int eop_cycs[$];
  int n_crc = 0, n_eop = 0, n_err = 0, n_overlap = 0, n_pkt_bad = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus.shift_en) begin
      rx_bits.push_back(bus.data_out);
      shift_cycs.push_back(cyc);
    end
    if (bus.crc_clr) n_crc++;
    if (bus.eop) begin
      n_eop++;
      eop_cycs.push_back(cyc);
    end
    if (bus.rx_err) n_err++;
    if (bus.crc_clr && (bus.eop || bus.rx_err)) n_overlap++;
    if ((bus.eop || bus.rx_err) && bus.pkt_active) n_pkt_bad++;
    if (bus.crc_clr && !bus.pkt_active) n_pkt_bad++;
  end

  // reference model: packet bits -> stuffed, NRZI-encoded wire symbols
  logic [1:0] tx_q[$];
  logic [1:0] tx_lvl;
  bit         exp_bits[$];
  int         ones_run;

  function automatic void put_raw(bit b);
    if (!b) tx_lvl = (tx_lvl == J) ? K : J;
    tx_q.push_back(tx_lvl);
  endfunction

  function automatic void start_pkt();
    tx_q.delete();
    exp_bits.delete();
    tx_lvl   = J;
    ones_run = 0;
    for (int i = 0; i < 7; i++) put_raw(1'b0);
    put_raw(1'b1);
  endfunction

  function automatic void put_data(bit b);
    put_raw(b);
    exp_bits.push_back(b);
    if (b) begin
      ones_run++;
      if (ones_run == 6) begin
        put_raw(1'b0);
        ones_run = 0;
      end
    end else begin
      ones_run = 0;
    end
  endfunction

  function automatic void put_byte(logic [7:0] v);
    for (int i = 0; i < 8; i++) put_data(v[i]);
  endfunction

  function automatic void put_eop();
    tx_q.push_back(SE0);
    tx_q.push_back(SE0);
    tx_q.push_back(J);
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      {bus.d_plus, bus.d_minus} = J;
    end
  endtask

  // consecutive edge offsets may differ by at most +3 so a stretched bit is never sampled twice
  task automatic drive_tx(input bit jit, output int last_cyc);
    int start[$];
    int jprev;
    int idx;
    int j;
    jprev = 0;
    for (int i = 0; i < tx_q.size(); i++) begin
      j = 0;
      if (jit && i > 0 && tx_q[i] != tx_q[i-1]) begin
        j = int'($urandom_range(0, 4)) - 2;
        if (j - jprev > 3) j = jprev + 3;
        jprev = j;
      end
      start.push_back(i * CPB + j);
    end
    idx      = 0;
    last_cyc = -1;
    for (int c = 0; c < tx_q.size() * CPB + CPB; c++) begin
      @(negedge clk);
      while (idx + 1 < tx_q.size() && start[idx+1] <= c) idx++;
      {bus.d_plus, bus.d_minus} = tx_q[idx];
      if (idx == tx_q.size() - 1 && last_cyc < 0) last_cyc = cyc + 1;
    end
  endtask

  task automatic test_reset();
    {bus.d_plus, bus.d_minus} = J;
    n_rst = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++;
    if ({bus.data_out, bus.shift_en, bus.crc_clr, bus.pkt_active, bus.eop, bus.rx_err} !== 6'b0) begin
      n_errors++;
      $display("FAIL reset_outputs: got %b required 000000",
               {bus.data_out, bus.shift_en, bus.crc_clr, bus.pkt_active, bus.eop, bus.rx_err});
    end
    n_rst = 1'b1;
    idle(200);
    n_checks++;
    if (rx_bits.size() + n_crc + n_eop + n_err + int'(bus.pkt_active) != 0) begin
      n_errors++;
      $display("FAIL idle_quiet: shifts=%0d crc=%0d eop=%0d err=%0d pkt=%b required all 0",
               rx_bits.size(), n_crc, n_eop, n_err, bus.pkt_active);
    end
  endtask

  task automatic test_clean_packet();
    int b_bits = rx_bits.size();
    int b_crc = n_crc, b_eop = n_eop, b_err = n_err;
    int b_eq = eop_cycs.size();
    int lc, bad, min_gap;
    start_pkt();
    put_byte(8'hA5);
    put_eop();
    drive_tx(1'b0, lc);
    idle(20);
    bad = -1;
    if (rx_bits.size() - b_bits != 8) bad = 99;
    for (int i = 0; bad < 0 && i < 8; i++) if (rx_bits[b_bits+i] !== exp_bits[i]) bad = i;
    n_checks++;
    if (bad >= 0) begin
      n_errors++;
      $display("FAIL clean_bits: %0d shifts, first bad index %0d, required 8 bits 1,0,1,0,0,1,0,1",
               rx_bits.size() - b_bits, bad);
    end
    n_checks++;
    if (n_crc - b_crc != 1 || n_eop - b_eop != 1 || n_err - b_err != 0) begin
      n_errors++;
      $display("FAIL clean_strobes: crc=%0d eop=%0d err=%0d required 1 1 0",
               n_crc - b_crc, n_eop - b_eop, n_err - b_err);
    end
    n_checks++;
    if (eop_cycs.size() <= b_eq || eop_cycs[b_eq] != lc + SP + 4) begin
      n_errors++;
      $display("FAIL clean_eop_latency: got cycle %0d required %0d",
               (eop_cycs.size() > b_eq) ? eop_cycs[b_eq] : -1, lc + SP + 4);
    end
    min_gap = 1000;
    for (int i = b_bits + 1; i < shift_cycs.size(); i++)
      if (shift_cycs[i] - shift_cycs[i-1] < min_gap) min_gap = shift_cycs[i] - shift_cycs[i-1];
    n_checks++;
    if (min_gap < CPB || bus.pkt_active !== 1'b0) begin
      n_errors++;
      $display("FAIL clean_spacing: min shift gap %0d pkt_active %b required gap>=%0d pkt_active 0",
               min_gap, bus.pkt_active, CPB);
    end
  endtask

  task automatic test_stuffing();
    int b_bits = rx_bits.size();
    int b_eop = n_eop, b_err = n_err;
    int lc, bad;
    start_pkt();
    put_byte(8'hFF);
    put_byte(8'h00);
    put_eop();
    drive_tx(1'b0, lc);
    idle(20);
    bad = -1;
    if (rx_bits.size() - b_bits != 16) bad = 99;
    for (int i = 0; bad < 0 && i < 16; i++) if (rx_bits[b_bits+i] !== (i < 8)) bad = i;
    n_checks++;
    if (bad >= 0) begin
      n_errors++;
      $display("FAIL stuff_bits: %0d shifts, first bad index %0d, required 8 ones then 8 zeros",
               rx_bits.size() - b_bits, bad);
    end
    n_checks++;
    if (n_eop - b_eop != 1 || n_err - b_err != 0) begin
      n_errors++;
      $display("FAIL stuff_strobes: eop=%0d err=%0d required 1 0", n_eop - b_eop, n_err - b_err);
    end
  endtask

  task automatic test_random_packets(input bit jit);
    int b_bits, b_eop, b_err, lc, bad, len;
    logic [7:0] v;
    for (int p = 0; p < 5; p++) begin
      b_bits = rx_bits.size();
      b_eop  = n_eop;
      b_err  = n_err;
      start_pkt();
      len = int'($urandom_range(1, 3));
      for (int k = 0; k < len; k++) begin
        v = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
        put_byte(v);
      end
      put_eop();
      drive_tx(jit, lc);
      idle(int'($urandom_range(10, 30)));
      bad = -1;
      if (rx_bits.size() - b_bits != exp_bits.size()) bad = 999;
      for (int i = 0; bad < 0 && i < exp_bits.size(); i++)
        if (rx_bits[b_bits+i] !== exp_bits[i]) bad = i;
      n_checks++;
      if (bad >= 0 || n_eop - b_eop != 1 || n_err - b_err != 0) begin
        n_errors++;
        $display("FAIL random_pkt jit=%0d #%0d: %0d shifts (bad idx %0d) eop=%0d err=%0d required %0d shifts eop=1 err=0",
                 jit, p, rx_bits.size() - b_bits, bad, n_eop - b_eop, n_err - b_err, exp_bits.size());
      end
    end
  endtask

  task automatic test_stuff_error();
    int b_bits = rx_bits.size();
    int b_eop = n_eop, b_err = n_err;
    int lc, ones;
    start_pkt();
    for (int i = 0; i < 7; i++) put_raw(1'b1);
    put_eop();
    drive_tx(1'b0, lc);
    idle(20);
    ones = 0;
    for (int i = b_bits; i < rx_bits.size(); i++) ones += int'(rx_bits[i]);
    n_checks++;
    if (rx_bits.size() - b_bits != 6 || ones != 6) begin
      n_errors++;
      $display("FAIL stuff_err_bits: %0d shifts (%0d ones) required 6 shifts all ones",
               rx_bits.size() - b_bits, ones);
    end
    n_checks++;
    if (n_err - b_err != 1 || n_eop - b_eop != 0 || bus.pkt_active !== 1'b0) begin
      n_errors++;
      $display("FAIL stuff_err_strobes: err=%0d eop=%0d pkt=%b required 1 0 0",
               n_err - b_err, n_eop - b_eop, bus.pkt_active);
    end
  endtask

  task automatic test_framing_error();
    int b_bits = rx_bits.size();
    int b_eop = n_eop, b_err = n_err;
    int lc;
    start_pkt();
    put_byte(8'($urandom));
    tx_q.push_back(SE0);
    tx_q.push_back(K);
    put_eop();
    drive_tx(1'b0, lc);
    idle(20);
    n_checks++;
    if (rx_bits.size() - b_bits != 8 || n_err - b_err != 1 || n_eop - b_eop != 0) begin
      n_errors++;
      $display("FAIL framing_err: shifts=%0d err=%0d eop=%0d required 8 1 0",
               rx_bits.size() - b_bits, n_err - b_err, n_eop - b_eop);
    end
  endtask

  task automatic test_idle_glitch();
    int b_bits = rx_bits.size();
    int b_crc = n_crc, b_err = n_err;
    for (int i = 0; i < CPB; i++) begin
      @(negedge clk);
      {bus.d_plus, bus.d_minus} = SE0;
    end
    idle(60);
    n_checks++;
    if (rx_bits.size() != b_bits || n_crc != b_crc || n_err != b_err) begin
      n_errors++;
      $display("FAIL idle_glitch: shifts=%0d crc=%0d err=%0d required 0 0 0",
               rx_bits.size() - b_bits, n_crc - b_crc, n_err - b_err);
    end
  endtask

  task automatic test_reset_mid();
    int b_bits = rx_bits.size();
    int b_eop, b_err, lc;
    start_pkt();
    for (int i = 0; i < 4; i++) put_data(1'($urandom));
    drive_tx(1'b0, lc);
    n_checks++;
    if (rx_bits.size() - b_bits < 4 || bus.pkt_active !== 1'b1) begin
      n_errors++;
      $display("FAIL mid_before_reset: shifts=%0d pkt=%b required >=4 and 1",
               rx_bits.size() - b_bits, bus.pkt_active);
    end
    b_eop = n_eop;
    b_err = n_err;
    @(negedge clk);
    n_rst = 1'b0;
    #1;
    n_checks++;
    if ({bus.data_out, bus.shift_en, bus.crc_clr, bus.pkt_active, bus.eop, bus.rx_err} !== 6'b0) begin
      n_errors++;
      $display("FAIL mid_reset_outputs: got %b required 000000",
               {bus.data_out, bus.shift_en, bus.crc_clr, bus.pkt_active, bus.eop, bus.rx_err});
    end
    idle(10);
    n_rst = 1'b1;
    idle(40);
    n_checks++;
    if (n_eop != b_eop || n_err != b_err) begin
      n_errors++;
      $display("FAIL mid_release_pulses: eop=%0d err=%0d required 0 0", n_eop - b_eop, n_err - b_err);
    end
  endtask

  task automatic test_invariants();
    n_checks++;
    if (n_overlap != 0 || n_pkt_bad != 0) begin
      n_errors++;
      $display("FAIL strobe_invariants: overlap=%0d pkt_active_misaligned=%0d required 0 0",
               n_overlap, n_pkt_bad);
    end
  endtask

  initial begin
    bus.d_plus  = 1'b1;
    bus.d_minus = 1'b0;
    test_reset();
    test_clean_packet();
    test_stuffing();
    test_random_packets(1'b0);
    test_stuff_error();
    test_clean_packet();
    test_random_packets(1'b1);
    test_framing_error();
    test_idle_glitch();
    test_reset_mid();
    test_clean_packet();
    test_invariants();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
